// File: rtl/pwm_peripheral.sv
// Sixteen-channel PWM output stage: prescaler + 8-bit step counter drive a shared
// PWM level; each channel is off, static on, or PWM. Optional macro PWM_SHADOW_DUTY_EN
// latches the duty cycle at each period boundary instead of using it live.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt;
  logic [7:0]  step_cnt;
  logic        tick;
  logic        wrap;
  logic [7:0]  duty_eff;
  logic        pwm_level;
  logic [15:0] eo;
  logic [15:0] ep;
  logic [15:0] out_next;

  assign eo   = {en_reg_out_15_8, en_reg_out_7_0};
  assign ep   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign tick = (pre_cnt == PRE_MAX);
  assign wrap = tick && (step_cnt == 8'hFF);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
    end else if (tick) begin
      pre_cnt  <= '0;
      step_cnt <= step_cnt + 8'd1;  // 255 -> 0 by natural overflow
    end else begin
      pre_cnt  <= pre_cnt + 16'd1;
    end
  end

`ifdef PWM_SHADOW_DUTY_EN
  logic [7:0] duty_shadow;

  // Duty only moves at the period boundary, so no period is ever split.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow <= 8'h00;
    end else if (wrap) begin
      duty_shadow <= pwm_duty_cycle;
    end
  end

  assign duty_eff = duty_shadow;
`else
  assign duty_eff = pwm_duty_cycle;
`endif

  // NOTE: every always_comb output is assigned unconditionally, so no latch.
  always_comb begin
    pwm_level = (duty_eff == 8'hFF) || (step_cnt < duty_eff);
    out_next  = eo & (~ep | {16{pwm_level}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out          <= 16'h0000;
      period_start <= 1'b0;
    end else begin
      out          <= out_next;
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed self-checking bench for pwm_peripheral: two instances (PRESCALE 13 and 2)
// share stimulus; expectations are hand-computed, with shadow-mode variants under the macro.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] eo;
  logic [15:0] ep;
  logic [7:0]  duty;
  logic [15:0] out13;
  logic [15:0] out2;
  logic        ps13;
  logic        ps2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_peripheral dut13 (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (eo[7:0]),
    .en_reg_out_15_8 (eo[15:8]),
    .en_reg_pwm_7_0  (ep[7:0]),
    .en_reg_pwm_15_8 (ep[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out13),
    .period_start    (ps13)
  );

  pwm_peripheral #(.PRESCALE(2)) dut2 (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (eo[7:0]),
    .en_reg_out_15_8 (eo[15:8]),
    .en_reg_pwm_7_0  (ep[7:0]),
    .en_reg_pwm_15_8 (ep[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out2),
    .period_start    (ps2)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to the next period_start pulse of the selected instance (1 = PRESCALE 2).
  task automatic sync(input bit sel);
    int n = 0;
    step();
    while (((sel ? ps2 : ps13) !== 1'b1) && n < 4000) begin
      step();
      n++;
    end
    check("sync_timeout", 32'(n < 4000), 32'd1);
  endtask

  initial begin
    int n;
    int hi;
    int bad_a;
    int bad_b;
    int bad_c;

    rst  = 1'b1;
    eo   = 16'h0000;
    ep   = 16'h0000;
    duty = 8'h00;
    repeat (3) step();
    check("reset_out13", 32'(out13), 32'h0000);
    check("reset_out2", 32'(out2), 32'h0000);
    check("reset_ps13", 32'(ps13), 32'd0);

    // Reset mid-period with all channels static on.
    eo  = 16'hFFFF;
    rst = 1'b0;
    step();
    check("static_on_first", 32'(out13), 32'hFFFF);
    repeat (100) step();
    check("static_on_mid", 32'(out13), 32'hFFFF);
    rst = 1'b1;
    step();
    check("midreset_out", 32'(out13), 32'h0000);
    check("midreset_ps", 32'(ps13), 32'd0);
    rst = 1'b0;
    step();
    check("post_reset_out", 32'(out13), 32'hFFFF);

    // Mode select on the PRESCALE=2 instance, duty 0x80.
    eo   = 16'h00FF;
    ep   = 16'h000F;
    duty = 8'h80;
    sync(1'b1);
    sync(1'b1);
    hi = 0; bad_a = 0; bad_b = 0; bad_c = 0;
    for (int i = 0; i < 512; i++) begin
      if (out2[15:8] !== 8'h00) bad_a++;
      if (out2[7:4] !== 4'hF) bad_b++;
      if (out2[3:0] !== {4{out2[0]}}) bad_c++;
      if (out2[0] === 1'b1) hi++;
      step();
    end
    check("mode_off_bits", 32'(bad_a), 32'd0);
    check("mode_static_bits", 32'(bad_b), 32'd0);
    check("mode_pwm_aligned", 32'(bad_c), 32'd0);
    check("mode_pwm_high", 32'(hi), 32'd256);
    check("mode_period_end", 32'(ps2), 32'd1);

    // Duty 0x00: never high across three periods.
    eo   = 16'hFFFF;
    ep   = 16'hFFFF;
    duty = 8'h00;
    sync(1'b0);
    sync(1'b0);
    bad_a = 0;
    for (int i = 0; i < 3 * 3328; i++) begin
      if (out13 !== 16'h0000) bad_a++;
      step();
    end
    check("duty00_high_cycles", 32'(bad_a), 32'd0);

    // Duty 0xFF: continuously high, including the step 255 slot.
    duty = 8'hFF;
    sync(1'b0);
    sync(1'b0);
    bad_a = 0;
    for (int i = 0; i < 3328; i++) begin
      if (out13 !== 16'hFFFF) bad_a++;
      step();
    end
    check("dutyFF_low_cycles", 32'(bad_a), 32'd0);

    // Period length and high time at PRESCALE=13, duty 0x40.
    duty = 8'h40;
    sync(1'b0);
    sync(1'b0);
    n = 0; hi = 0;
    do begin
      if (out13[0] === 1'b1) hi++;
      step();
      n++;
    end while (ps13 !== 1'b1 && n < 4000);
    check("period_len", 32'(n), 32'd3328);
    check("period_high", 32'(hi), 32'd832);

    // Duty change 0x20 -> 0xC0 at step_cnt 0x10 (cycle 208 of the period).
    duty = 8'h20;
    sync(1'b0);
    sync(1'b0);
    hi = 0;
    for (int i = 0; i < 3328; i++) begin
      if (out13[0] === 1'b1) hi++;
      if (i == 208) duty = 8'hC0;
      if (i == 210) check("change_out_high", 32'(out13[0]), 32'd1);
      step();
    end
    check("change_period_end", 32'(ps13), 32'd1);
`ifdef PWM_SHADOW_DUTY_EN
    check("change_cur_high", 32'(hi), 32'd416);
`else
    check("change_cur_high", 32'(hi), 32'd2496);
`endif
    hi = 0;
    for (int i = 0; i < 3328; i++) begin
      if (out13[0] === 1'b1) hi++;
      step();
    end
    check("change_next_high", 32'(hi), 32'd2496);

    // Live output-enable toggle during the high phase.
    repeat (20) step();
    check("live_before", 32'(out13[0]), 32'd1);
    eo = 16'hFFFE;
    check("live_not_yet", 32'(out13[0]), 32'd1);
    step();
    check("live_disabled", 32'(out13[0]), 32'd0);
    check("live_neighbor", 32'(out13[1]), 32'd1);
    eo = 16'hFFFF;
    step();
    check("live_reenabled", 32'(out13[0]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
